// File: rtl/popcount_acc.sv
// popcount_acc: three-stage pipelined population-count accumulator.
//
// Each valid beat carries IN_WIDTH one-bit results. The ones are counted and
// the counts are summed over a frame delimited by in_first/in_last. One frame
// total is emitted per last beat, with a sticky overflow flag.
//
// Build option: define POPCOUNT_ACC_SAT_EN to saturate the accumulator at
// 2^ACC_WIDTH-1 on carry-out. When it is undefined the accumulator wraps.
// acc_ovf is set in either build.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_b     in   asynchronous active-low reset
//   flush     in   synchronous clear of the pipeline and accumulator
//   in_valid  in   beat qualifier
//   in_first  in   beat opens a frame (only meaningful with in_valid)
//   in_last   in   beat closes a frame (only meaningful with in_valid)
//   in_data   in   IN_WIDTH bits to count
//   beat_cnt  out  registered per-beat count (debug)
//   acc_out   out  frame total, held until the next output
//   acc_ovf   out  frame total exceeded the ACC_WIDTH range
//   out_valid out  one-cycle pulse qualifying acc_out/acc_ovf
module popcount_acc #(
    parameter  int unsigned IN_WIDTH  = 64,
    parameter  int unsigned ACC_WIDTH = 16,
    localparam int unsigned CNT_W     = $clog2(IN_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic [CNT_W-1:0]     beat_cnt,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 acc_ovf,
    output logic                 out_valid
);

    localparam int unsigned NSL   = IN_WIDTH / 8;
    localparam int unsigned SUM_W = ACC_WIDTH + 1;

    if ((IN_WIDTH < 8) || ((IN_WIDTH % 8) != 0)) begin : g_bad_in_width
        $error("popcount_acc: IN_WIDTH must be a multiple of 8 and at least 8");
    end
    if (ACC_WIDTH < CNT_W) begin : g_bad_acc_width
        $error("popcount_acc: ACC_WIDTH must be at least CNT_W");
    end

    // Stage 1: per-byte counts
    logic [3:0]       slice_d [NSL];
    logic [3:0]       slice_q [NSL];
    logic             v1_q, f1_q, l1_q;

    // Stage 2: beat total
    logic [CNT_W-1:0] tot_d, tot_q;
    logic             v2_q, f2_q, l2_q;

    // Stage 3: accumulator and output registers
    logic [ACC_WIDTH-1:0] acc_d, acc_q;
    logic                 ovf_d, ovf_q;
    logic [ACC_WIDTH-1:0] acc_out_d, acc_out_q;
    logic                 acc_ovf_d, acc_ovf_q;
    logic                 out_valid_d, out_valid_q;

    logic [ACC_WIDTH-1:0] acc_base;
    logic                 ovf_base;
    logic [SUM_W-1:0]     acc_sum;
    logic [ACC_WIDTH-1:0] acc_upd;
    logic                 ovf_upd;

    always_comb begin
        for (int unsigned s = 0; s < NSL; s++) begin
            slice_d[s] = '0;
            for (int unsigned b = 0; b < 8; b++) begin
                slice_d[s] = slice_d[s] + 4'(in_data[s*8 + b]);
            end
        end
    end

    always_comb begin
        tot_d = '0;
        for (int unsigned s = 0; s < NSL; s++) begin
            tot_d = tot_d + CNT_W'(slice_q[s]);
        end
    end

    always_comb begin
        // A first beat restarts from zero, which also drops any open frame.
        acc_base = f2_q ? '0 : acc_q;
        ovf_base = f2_q ? 1'b0 : ovf_q;
        acc_sum  = {1'b0, acc_base} + SUM_W'(tot_q);
`ifdef POPCOUNT_ACC_SAT_EN
        acc_upd  = acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];
`else
        acc_upd  = acc_sum[ACC_WIDTH-1:0];
`endif
        ovf_upd  = ovf_base | acc_sum[ACC_WIDTH];

        acc_d       = acc_q;
        ovf_d       = ovf_q;
        acc_out_d   = acc_out_q;
        acc_ovf_d   = acc_ovf_q;
        out_valid_d = 1'b0;
        if (flush) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (v2_q) begin
            acc_d = acc_upd;
            ovf_d = ovf_upd;
            if (l2_q) begin
                acc_out_d   = acc_upd;
                acc_ovf_d   = ovf_upd;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int unsigned s = 0; s < NSL; s++) begin
                slice_q[s] <= '0;
            end
            v1_q        <= 1'b0;
            f1_q        <= 1'b0;
            l1_q        <= 1'b0;
            tot_q       <= '0;
            v2_q        <= 1'b0;
            f2_q        <= 1'b0;
            l2_q        <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            acc_out_q   <= '0;
            acc_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            for (int unsigned s = 0; s < NSL; s++) begin
                slice_q[s] <= slice_d[s];
            end
            v1_q        <= in_valid & ~flush;
            f1_q        <= in_first;
            l1_q        <= in_last;
            tot_q       <= tot_d;
            v2_q        <= v1_q & ~flush;
            f2_q        <= f1_q;
            l2_q        <= l1_q;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            acc_out_q   <= acc_out_d;
            acc_ovf_q   <= acc_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign beat_cnt  = tot_q;
    assign acc_out   = acc_out_q;
    assign acc_ovf   = acc_ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_popcount_acc.sv
// tb_popcount_acc: self-checking bench for popcount_acc. Two instances share
// the stimulus: a 16-bit accumulator and an 8-bit one (to reach overflow).
// Expected values come from an unbounded-integer frame-sum model.
module tb_popcount_acc;

    logic        clk = 1'b0;
    logic        rst_b, flush, in_valid, in_first, in_last;
    logic [63:0] in_data;
    logic [6:0]  bc16, bc8;
    logic [15:0] ao16;
    logic [7:0]  ao8;
    logic        ov16, ov8, vo16, vo8;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    popcount_acc #(.IN_WIDTH(64), .ACC_WIDTH(16)) u_dut16 (
        .clk(clk), .rst_b(rst_b), .flush(flush), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .in_data(in_data),
        .beat_cnt(bc16), .acc_out(ao16), .acc_ovf(ov16), .out_valid(vo16)
    );

    popcount_acc #(.IN_WIDTH(64), .ACC_WIDTH(8)) u_dut8 (
        .clk(clk), .rst_b(rst_b), .flush(flush), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .in_data(in_data),
        .beat_cnt(bc8), .acc_out(ao8), .acc_ovf(ov8), .out_valid(vo8)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        bit f;
        bit l;
        bit fl;
        int cnt;
    } rec_t;

    rec_t   hist [3];   // hist[0] = beat sampled at the latest edge
    longint tot;        // unbounded running frame sum
    longint exp_bc, exp_vo, exp_ao16, exp_ov16, exp_ao8, exp_ov8;

    function automatic longint fold(longint t, int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
`ifdef POPCOUNT_ACC_SAT_EN
        return (t > mx) ? mx : t;
`else
        return t % (mx + 1);
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0, 0};
        tot = 0;
        exp_bc = 0; exp_vo = 0;
        exp_ao16 = 0; exp_ov16 = 0; exp_ao8 = 0; exp_ov8 = 0;
    endtask

    task automatic model_edge();
        bit dropped;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = '{in_valid, in_first, in_last, flush, $countones(in_data)};
        exp_bc  = hist[1].cnt;
        exp_vo  = 0;
        // A beat finishes two edges after sampling; a flush on any of those
        // three edges drops it.
        dropped = hist[0].fl | hist[1].fl | hist[2].fl;
        if (hist[0].fl) begin
            tot = 0;
        end else if (!dropped && hist[2].v) begin
            if (hist[2].f) tot = hist[2].cnt;
            else           tot = tot + hist[2].cnt;
            if (hist[2].l) begin
                exp_vo   = 1;
                exp_ao16 = fold(tot, 16);
                exp_ov16 = (tot > 65535) ? 1 : 0;
                exp_ao8  = fold(tot, 8);
                exp_ov8  = (tot > 255) ? 1 : 0;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out_valid16", 64'(vo16), exp_vo);
        chk("out_valid8",  64'(vo8),  exp_vo);
        chk("beat_cnt16",  64'(bc16), exp_bc);
        chk("beat_cnt8",   64'(bc8),  exp_bc);
        chk("acc_out16",   64'(ao16), exp_ao16);
        chk("acc_ovf16",   64'(ov16), exp_ov16);
        chk("acc_out8",    64'(ao8),  exp_ao8);
        chk("acc_ovf8",    64'(ov8),  exp_ov8);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_b) model_edge();
        else       model_reset();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(bit v, bit f, bit l, logic [63:0] d, bit fl);
        in_valid = v; in_first = f; in_last = l; in_data = d; flush = fl;
        cyc();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, '0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_b = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_first = 1'b0; in_last = 1'b0; in_data = '0;
        model_reset();
        cyc();
        cyc();
        rst_b = 1'b1;
        idle(1);

        // single first+last beat, all ones
        drive(1, 1, 1, '1, 0);
        idle(4);

        // 4-beat frame with an idle cycle: 1 + 8 + 33 + 0 = 42
        drive(1, 1, 0, 64'h1, 0);
        drive(1, 0, 0, 64'hFF, 0);
        idle(1);
        drive(1, 0, 0, 64'h1_FFFF_FFFF, 0);
        drive(1, 0, 1, 64'h0, 0);
        idle(4);

        // back-to-back frames
        drive(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        drive(1, 1, 0, 64'h0F, 0);
        drive(1, 0, 1, 64'h0F, 0);
        idle(4);

        // 5 all-ones beats (320) then a 3-count frame
        drive(1, 1, 0, '1, 0);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, '1, 0);
        drive(1, 0, 1, '1, 0);
        idle(4);
        drive(1, 1, 1, 64'h7, 0);
        idle(4);

        // flush one cycle after a first beat, then a 5-count frame
        drive(1, 1, 0, '1, 0);
        drive(0, 0, 0, '0, 1);
        drive(1, 1, 1, 64'h1F, 0);
        idle(4);

        // flush overriding a valid beat on the same edge
        drive(1, 1, 0, 64'hF0F0, 0);
        drive(1, 0, 1, 64'hFF, 1);
        idle(4);

        // asynchronous reset mid-frame
        drive(1, 1, 0, '1, 0);
        drive(1, 0, 0, '1, 0);
        #2 rst_b = 1'b0;
        #1 model_reset();
        check_all();
        cyc();
        rst_b = 1'b1;
        idle(4);
        drive(1, 1, 1, 64'h3, 0);
        idle(4);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [63:0] d;
            case ($urandom_range(0, 3))
                0:       d = '1;
                1:       d = '0;
                default: d = {$urandom, $urandom};
            endcase
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 3) == 0), d, ($urandom_range(0, 39) == 0));
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
